// File: rtl/shift_deserializer.sv
// LSB-first serial-to-parallel receiver with a valid/ready word output.
// Flags sync arriving mid-word (frame_err) and words lost to an unread output (overrun).
module shift_deserializer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sh_in,
    input  logic         sh_en,
    input  logic         sync,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         frame_err,
    output logic         overrun
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    generate
        if (N < 2) begin : g_bad_width
            $error("shift_deserializer: N must be at least 2");
        end
    endgenerate

    state_t        state_q, state_d;
    logic [N-1:0]  s_reg_q, s_reg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic [N-1:0]  shifted;
    logic          transfer;

    assign shifted  = {sh_in, s_reg_q[N-1:1]};
    assign transfer = valid_q & data_ready;

    // Next-state: bit capture, word completion and handshake
    always_comb begin
        state_d     = state_q;
        s_reg_d     = s_reg_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (transfer) begin
            valid_d = 1'b0;
        end

        if (sh_en) begin
            unique case (state_q)
                IDLE: begin
                    if (sync) begin
                        s_reg_d = shifted;
                        cnt_d   = CW'(1);
                        state_d = RECV;
                    end
                end
                RECV: begin
                    s_reg_d = shifted;
                    if (sync) begin
                        // Restart the word on this bit; a non-zero count means a partial word is dropped
                        frame_err_d = (cnt_q != '0);
                        cnt_d       = CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        data_d    = shifted;
                        valid_d   = 1'b1;
                        overrun_d = valid_q & ~data_ready;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            s_reg_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_reg_q     <= s_reg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: directed words, queue of expected transfers,
// independent monitor comparing on every handshake.
module tb_shift_deserializer;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         sh_in;
    logic         sh_en;
    logic         sync;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         frame_err;
    logic         overrun;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;

    logic [N-1:0] exp_q[$];

    shift_deserializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sh_in      (sh_in),
        .sh_en      (sh_en),
        .sync       (sync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake pops one expected word; also tallies flag pulses
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none at %0t", data_out, $time);
                end else begin
                    automatic logic [N-1:0] e = exp_q.pop_front();
                    check("handshake_word", 32'(data_out), 32'(e));
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sh_in = b;
        sh_en = 1'b1;
        sync  = s;
        tick();
        sh_en = 1'b0;
        sync  = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic first_sync, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                automatic int g = $urandom_range(0, 3);
                for (int k = 0; k < g; k++) tick();
            end
            send_bit(w[i], first_sync && (i == 0));
        end
    endtask

    initial begin
        automatic logic [N-1:0] w;

        rst        = 1'b0;
        sh_in      = 1'b0;
        sh_en      = 1'b0;
        sync       = 1'b0;
        data_ready = 1'b0;

        // Reset with random activity on inputs
        for (int i = 0; i < 5; i++) begin
            sh_in = 1'($urandom);
            sh_en = 1'($urandom);
            sync  = 1'($urandom);
            tick();
        end
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        sh_en = 1'b0;
        sync  = 1'b0;
        rst   = 1'b1;
        data_ready = 1'b1;
        tick();

        // Bits without sync are ignored in IDLE
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        tick();
        check("idle_ignored_valid", 32'(data_valid), 32'h0);

        // Single word, one-cycle valid
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 1'b1, 1'b0);
        check("single_valid", 32'(data_valid), 32'h1);
        check("single_data", 32'(data_out), 32'hA5);
        tick();
        check("single_valid_drop", 32'(data_valid), 32'h0);

        // Streaming with random gaps, one sync only
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_word(8'h3C, 1'b1, 1'b1);
        send_word(8'hC3, 1'b0, 1'b1);
        tick();
        tick();
        check("stream_drained", 32'(exp_q.size()), 32'h0);
        check("stream_no_fe", 32'(fe_cnt), 32'h0);
        check("stream_no_ov", 32'(ov_cnt), 32'h0);

        // Overrun: newest word wins
        data_ready = 1'b0;
        send_word(8'h11, 1'b1, 1'b0);
        check("ovr_first_no_flag", 32'(overrun), 32'h0);
        send_word(8'h22, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_data", 32'(data_out), 32'h22);
        tick();
        check("ovr_pulse_end", 32'(overrun), 32'h0);
        check("ovr_valid_held", 32'(data_valid), 32'h1);
        check("ovr_data_held", 32'(data_out), 32'h22);
        exp_q.push_back(8'h22);
        data_ready = 1'b1;
        tick();
        check("ovr_valid_drop", 32'(data_valid), 32'h0);
        check("ovr_count", 32'(ov_cnt), 32'h1);

        // Frame error: sync after 3 bits restarts the word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        w = 8'h5A;
        exp_q.push_back(8'h5A);
        send_bit(w[0], 1'b1);
        check("fe_pulse", 32'(frame_err), 32'h1);
        send_bit(w[1], 1'b0);
        check("fe_pulse_end", 32'(frame_err), 32'h0);
        for (int i = 2; i < N; i++) send_bit(w[i], 1'b0);
        check("fe_data", 32'(data_out), 32'h5A);
        check("fe_valid", 32'(data_valid), 32'h1);
        // Sync exactly on a word boundary is not an error
        exp_q.push_back(8'h96);
        send_word(8'h96, 1'b1, 1'b0);
        check("boundary_sync_data", 32'(data_out), 32'h96);
        tick();
        check("boundary_sync_no_fe", 32'(fe_cnt), 32'h1);

        // Transfer and completion on the same edge
        data_ready = 1'b0;
        send_word(8'h0F, 1'b0, 1'b0);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hF0);
        w = 8'hF0;
        for (int i = 0; i < N - 1; i++) send_bit(w[i], 1'b0);
        data_ready = 1'b1;
        send_bit(w[N-1], 1'b0);
        check("simul_data", 32'(data_out), 32'hF0);
        check("simul_valid", 32'(data_valid), 32'h1);
        check("simul_no_overrun", 32'(overrun), 32'h0);
        tick();
        check("simul_valid_drop", 32'(data_valid), 32'h0);

        // Reset mid-word with a pending word
        data_ready = 1'b0;
        send_word(8'h77, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("pre_rst_valid", 32'(data_valid), 32'h1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(data_valid), 32'h0);
        check("async_rst_data", 32'(data_out), 32'h0);
        tick();
        rst = 1'b1;
        data_ready = 1'b1;
        tick();
        send_word(8'hFF, 1'b0, 1'b0);
        tick();
        check("post_rst_ignored", 32'(data_valid), 32'h0);
        exp_q.push_back(8'h3A);
        send_word(8'h3A, 1'b1, 1'b0);
        check("post_rst_word", 32'(data_out), 32'h3A);

        for (int i = 0; i < 4; i++) tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_fe_count", 32'(fe_cnt), 32'h1);
        check("final_ov_count", 32'(ov_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
